// File: rtl/qeciphy_faw_inserter.sv
// rtl/qeciphy_faw_inserter.sv - TX framer inserting FAW training bursts, period markers and idle fill
module qeciphy_faw_inserter #(
    parameter int FAW_INTERVAL = 256,
    parameter int ALIGN_WORDS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [63:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic [63:0] tx_data_o,
    output logic [7:0]  tx_charisk_o,
    output logic        faw_o,
    output logic        aligning_o
);

    localparam int SW = $clog2(FAW_INTERVAL);
    localparam int AW = $clog2(ALIGN_WORDS) + 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(FAW_INTERVAL - 1);
    localparam logic [SW-1:0] SLOT_ONE   = SW'(1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_WORDS - 1);
    localparam logic [AW-1:0] ALIGN_ONE  = AW'(1);

    // Byte comma in lane 0, word comma in lane 4; K flags mark exactly those two bytes.
    localparam logic [63:0] FAW_WORD = 64'h0000_00CB_0000_00BC;
    localparam logic [7:0]  FAW_K    = 8'h11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] slot_cnt, slot_nx;
    logic [AW-1:0] align_cnt, align_nx;
    logic [63:0]   data_nx;
    logic [7:0]    k_nx;
    logic          faw_nx;
    logic          aligning_nx;

    // Slot 0 of every period is reserved for the marker FAW, so user words are only taken elsewhere.
    assign s_tready_o = (state == DATA) && (slot_cnt != '0);

    // Next-state and next-output decision; the word loaded at an edge is chosen by the current state.
    always_comb begin
        state_nx    = state;
        slot_nx     = slot_cnt;
        align_nx    = align_cnt;
        data_nx     = '0;
        k_nx        = '0;
        faw_nx      = 1'b0;
        aligning_nx = 1'b0;

        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_nx = ALIGN;
                    align_nx = '0;
                end
            end
            ALIGN: begin
                data_nx     = FAW_WORD;
                k_nx        = FAW_K;
                faw_nx      = 1'b1;
                aligning_nx = 1'b1;
                if (align_cnt == ALIGN_LAST) begin
                    // The last training FAW doubles as slot 0 of the first period.
                    state_nx = DATA;
                    slot_nx  = SLOT_ONE;
                    align_nx = '0;
                end else begin
                    align_nx = align_cnt + ALIGN_ONE;
                end
            end
            DATA: begin
                if (s_tready_o && s_tvalid_i) begin
                    data_nx = s_tdata_i;
                end else begin
                    data_nx = FAW_WORD;
                    k_nx    = FAW_K;
                    faw_nx  = 1'b1;
                end
                slot_nx = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SLOT_ONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A word accepted this cycle is still sent; only the sequencing state is dropped.
        if (!enable_i) begin
            state_nx = IDLE;
            slot_nx  = '0;
            align_nx = '0;
        end
    end

    // State, counters and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            align_cnt    <= '0;
            tx_data_o    <= '0;
            tx_charisk_o <= '0;
            faw_o        <= 1'b0;
            aligning_o   <= 1'b0;
        end else begin
            state        <= state_nx;
            slot_cnt     <= slot_nx;
            align_cnt    <= align_nx;
            tx_data_o    <= data_nx;
            tx_charisk_o <= k_nx;
            faw_o        <= faw_nx;
            aligning_o   <= aligning_nx;
        end
    end

endmodule

// File: tb/tb_qeciphy_faw_inserter.sv
// tb/tb_qeciphy_faw_inserter.sv - directed self-checking bench for qeciphy_faw_inserter
module tb_qeciphy_faw_inserter;

    localparam int FAW_INTERVAL = 8;
    localparam int ALIGN_WORDS  = 4;
    localparam logic [63:0] FAW_WORD = 64'h0000_00CB_0000_00BC;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [63:0] s_tdata_i;
    logic        s_tvalid_i;
    logic        s_tready_o;
    logic [63:0] tx_data_o;
    logic [7:0]  tx_charisk_o;
    logic        faw_o;
    logic        aligning_o;

    int checks = 0;
    int errors = 0;
    int slot   = 0;
    logic [63:0] d;
    logic        acc;

    qeciphy_faw_inserter #(
        .FAW_INTERVAL(FAW_INTERVAL),
        .ALIGN_WORDS (ALIGN_WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .s_tdata_i   (s_tdata_i),
        .s_tvalid_i  (s_tvalid_i),
        .s_tready_o  (s_tready_o),
        .tx_data_o   (tx_data_o),
        .tx_charisk_o(tx_charisk_o),
        .faw_o       (faw_o),
        .aligning_o  (aligning_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_faw(input string tag);
        chk({tag, "_data"}, tx_data_o, FAW_WORD);
        chk({tag, "_k"}, {56'd0, tx_charisk_o}, 64'h11);
        chk({tag, "_faw"}, {63'd0, faw_o}, 64'd1);
    endtask

    task automatic expect_word(input string tag, input logic [63:0] w);
        chk({tag, "_data"}, tx_data_o, w);
        chk({tag, "_k"}, {56'd0, tx_charisk_o}, 64'h0);
        chk({tag, "_faw"}, {63'd0, faw_o}, 64'd0);
    endtask

    // One DATA-state cycle: check ready, clock, check the word loaded at that edge.
    task automatic data_cycle(input string tag, input logic v, input logic [63:0] w,
                              output logic accepted);
        logic exp_ready;
        exp_ready  = (slot != 0);
        s_tvalid_i = v;
        s_tdata_i  = w;
        #1;
        chk({tag, "_tready"}, {63'd0, s_tready_o}, {63'd0, exp_ready});
        tick();
        accepted = exp_ready && v;
        if (accepted) expect_word(tag, w);
        else expect_faw(tag);
        slot = (slot + 1) % FAW_INTERVAL;
    endtask

    task automatic align_burst(input string tag);
        for (int i = 0; i < ALIGN_WORDS; i++) begin
            tick();
            expect_faw(tag);
            chk({tag, "_aligning"}, {63'd0, aligning_o}, 64'd1);
            chk({tag, "_tready"}, {63'd0, s_tready_o}, {63'd0, (i == ALIGN_WORDS - 1)});
        end
        slot = 1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        s_tvalid_i = 1'b0;
        s_tdata_i  = '0;
        tick();
        tick();
        chk("rst_data", tx_data_o, 64'd0);
        chk("rst_k", {56'd0, tx_charisk_o}, 64'd0);
        chk("rst_faw", {63'd0, faw_o}, 64'd0);
        chk("rst_aligning", {63'd0, aligning_o}, 64'd0);
        chk("rst_tready", {63'd0, s_tready_o}, 64'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_data", tx_data_o, 64'd0);

        // Training: one IDLE-exit edge, then exactly ALIGN_WORDS FAWs.
        enable_i = 1'b1;
        tick();
        chk("exit_data", tx_data_o, 64'd0);
        chk("exit_aligning", {63'd0, aligning_o}, 64'd0);
        chk("exit_tready", {63'd0, s_tready_o}, 64'd0);
        align_burst("train");

        // Periodic: continuous valid data with counting payload.
        d = 64'h1000;
        for (int i = 0; i < 20; i++) begin
            data_cycle("period", 1'b1, d, acc);
            if (acc) d = d + 64'd1;
        end

        // Fill: three idle cycles, then resume; marker stays on schedule.
        for (int i = 0; i < 3; i++) data_cycle("fill", 1'b0, 64'hDEAD, acc);
        for (int i = 0; i < 10; i++) begin
            data_cycle("resume", 1'b1, d, acc);
            if (acc) d = d + 64'd1;
        end

        // Aliasing: user word equal to FAW pattern goes out as plain data.
        while (slot == 0) data_cycle("pre_alias", 1'b0, 64'd0, acc);
        data_cycle("alias", 1'b1, FAW_WORD, acc);

        // Disable for one cycle mid-DATA; the word accepted in that cycle is still sent.
        while (slot == 0) data_cycle("pre_dis", 1'b0, 64'd0, acc);
        enable_i   = 1'b0;
        s_tvalid_i = 1'b1;
        s_tdata_i  = 64'hA5A5_0000_1234_5678;
        #1;
        chk("dis_tready_before", {63'd0, s_tready_o}, 64'd1);
        tick();
        expect_word("dis", 64'hA5A5_0000_1234_5678);
        chk("dis_tready_after", {63'd0, s_tready_o}, 64'd0);
        s_tvalid_i = 1'b0;
        enable_i   = 1'b1;
        tick();
        chk("reidle_data", tx_data_o, 64'd0);
        chk("reidle_aligning", {63'd0, aligning_o}, 64'd0);
        chk("reidle_tready", {63'd0, s_tready_o}, 64'd0);
        align_burst("retrain");
        for (int i = 0; i < 9; i++) begin
            data_cycle("after_re", 1'b1, d, acc);
            if (acc) d = d + 64'd1;
        end

        // Asynchronous reset mid-DATA: outputs clear without waiting for an edge.
        while (slot == 0) data_cycle("pre_rst", 1'b0, 64'd0, acc);
        data_cycle("pre_rst_word", 1'b1, 64'h0123_4567_89AB_CDEF, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", tx_data_o, 64'd0);
        chk("arst_k", {56'd0, tx_charisk_o}, 64'd0);
        chk("arst_faw", {63'd0, faw_o}, 64'd0);
        chk("arst_tready", {63'd0, s_tready_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
